lcd_read_unit: RTL and testbench

//  Read-side companion to the 4-bit character-LCD write path on the Spartan-3E board.

---
 rtl/lcd_read_unit_if.sv | 25 ++
 rtl/lcd_read_unit.sv | 146 ++++++++++++++
 tb/tb_lcd_read_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lcd_read_unit_if.sv
// Bus bundle between the LCD read unit, its requester and the LCD pads.
// Only the input side of the SF_D tri-state pad enters this unit.
interface lcd_read_unit_if;
    logic       rd_req;
    logic       rd_rs;
    logic [3:0] SF_D;
    logic       rd_busy;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;

    modport master (
        output rd_req, rd_rs, SF_D,
        input  rd_busy, rd_valid, rd_data,
        input  LCD_E, LCD_RS, LCD_RW
    );

    modport slave (
        input  rd_req, rd_rs, SF_D,
        output rd_busy, rd_valid, rd_data,
        output LCD_E, LCD_RS, LCD_RW
    );
endinterface

// File: rtl/lcd_read_unit.sv
// HD44780 4-bit read: two enable strobes, high nibble first, byte assembled.
// All pad-facing outputs are registered so LCD_E never glitches.
module lcd_read_unit #(
    parameter int T_SETUP  = 2,
    parameter int T_E_HIGH = 12,
    parameter int T_HOLD   = 1,
    parameter int T_GAP    = 50
) (
    input  logic clk,
    input  logic reset,
    lcd_read_unit_if.slave bus
);
    localparam int M1    = (T_SETUP > T_E_HIGH) ? T_SETUP : T_E_HIGH;
    localparam int M2    = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int T_MAX = (M1 > M2) ? M1 : M2;
    localparam int CW    = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_EHI   = CW'(T_E_HIGH - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_GAP   = CW'(T_GAP - 1);

    typedef enum logic [3:0] {
        IDLE, SETUP_H, EHI_H, HOLD_H, GAP,
        SETUP_L, EHI_L, HOLD_L, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    hi_q, hi_d;
    logic [3:0]    lo_q, lo_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          e_q, e_d;
    logic          lrs_q, lrs_d;
    logic          rw_q, rw_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          cnt_zero;
    logic          act;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - CW'(1);
        hi_d    = hi_q;
        lo_d    = lo_q;
        rs_d    = rs_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.rd_req) begin
                    state_d = SETUP_H;
                    cnt_d   = LD_SETUP;
                    rs_d    = bus.rd_rs;
                end
            end
            SETUP_H: if (cnt_zero) begin
                state_d = EHI_H;
                cnt_d   = LD_EHI;
            end
            EHI_H: if (cnt_zero) begin
                state_d = HOLD_H;
                cnt_d   = LD_HOLD;
                hi_d    = bus.SF_D;
            end
            HOLD_H: if (cnt_zero) begin
                state_d = GAP;
                cnt_d   = LD_GAP;
            end
            GAP: if (cnt_zero) begin
                state_d = SETUP_L;
                cnt_d   = LD_SETUP;
            end
            SETUP_L: if (cnt_zero) begin
                state_d = EHI_L;
                cnt_d   = LD_EHI;
            end
            EHI_L: if (cnt_zero) begin
                state_d = HOLD_L;
                cnt_d   = LD_HOLD;
                lo_d    = bus.SF_D;
            end
            HOLD_L: if (cnt_zero) begin
                state_d = DONE;
                cnt_d   = '0;
                data_d  = {hi_q, lo_q};
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs follow the next state so they change on the same edge.
    always_comb begin
        act     = (state_d != IDLE) && (state_d != DONE);
        e_d     = (state_d == EHI_H) || (state_d == EHI_L);
        rw_d    = act;
        lrs_d   = act && rs_d;
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rs_q    <= 1'b0;
            data_q  <= '0;
            e_q     <= 1'b0;
            lrs_q   <= 1'b0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            e_q     <= e_d;
            lrs_q   <= lrs_d;
            rw_q    <= rw_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign bus.LCD_E    = e_q;
    assign bus.LCD_RS   = lrs_q;
    assign bus.LCD_RW   = rw_q;
    assign bus.rd_busy  = busy_q;
    assign bus.rd_valid = valid_q;
    assign bus.rd_data  = data_q;
endmodule

// File: tb/tb_lcd_read_unit.sv
// Directed and randomized bench for lcd_read_unit.
// Expected waveforms come from the phase timing arithmetic.
module tb_lcd_read_unit;
    localparam int TS  = 2;
    localparam int TE  = 12;
    localparam int TH  = 1;
    localparam int TG  = 50;
    localparam int L0  = TS + TE + TH + TG;
    localparam int LAT = 2 * (TS + TE + TH) + TG + 1;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;
    logic [7:0] exp_data = 8'h00;

    lcd_read_unit_if bus ();

    lcd_read_unit dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic bit win_h(int k);
        return (k > TS) && (k <= TS + TE);
    endfunction

    function automatic bit win_l(int k);
        return (k > L0 + TS) && (k <= L0 + TS + TE);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"},
            {3'b0, bus.rd_busy, bus.rd_valid, bus.LCD_E,
             bus.LCD_RS, bus.LCD_RW}, 8'h00);
        chk({tag, "_data"}, bus.rd_data, exp_data);
    endtask

    // Starts in IDLE a little after an edge; ends at the negedge of
    // the first idle cycle following DONE.
    task automatic run_read(input bit rs, input logic [3:0] hi,
                            input logic [3:0] lo, input bit pulses,
                            input bit hold_req);
        int nvalid;
        bit act;
        nvalid = 0;
        bus.rd_rs  = rs;
        bus.rd_req = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= LAT; k++) begin
            bus.rd_req = (pulses && (k == 10 || k == 40)) ||
                         (hold_req && k >= 70);
            bus.rd_rs  = 1'($urandom);
            if (win_h(k))      bus.SF_D = hi;
            else if (win_l(k)) bus.SF_D = lo;
            else               bus.SF_D = 4'($urandom);
            @(negedge clk);
            act = (k < LAT);
            if (k == LAT) exp_data = {hi, lo};
            chk($sformatf("E@%0d", k), 8'(bus.LCD_E),
                8'(win_h(k) || win_l(k)));
            chk($sformatf("RW@%0d", k), 8'(bus.LCD_RW), 8'(act));
            chk($sformatf("RS@%0d", k), 8'(bus.LCD_RS), 8'(act && rs));
            chk($sformatf("busy@%0d", k), 8'(bus.rd_busy), 8'h01);
            chk($sformatf("valid@%0d", k), 8'(bus.rd_valid),
                8'(k == LAT));
            chk($sformatf("data@%0d", k), bus.rd_data, exp_data);
            nvalid += int'(bus.rd_valid);
            @(posedge clk);
            #1;
        end
        bus.SF_D = 4'($urandom);
        @(negedge clk);
        chk_idle("post_read");
        chk("valid_count", 8'(nvalid), 8'h01);
    endtask

    initial begin
        reset      = 1'b1;
        bus.rd_req = 1'b0;
        bus.rd_rs  = 1'b0;
        bus.SF_D   = 4'h0;
        #12;
        chk_idle("reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.SF_D  = 4'($urandom);
            bus.rd_rs = 1'($urandom);
            @(negedge clk);
            chk_idle($sformatf("quiet%0d", i));
        end

        run_read(1'b0, 4'h8, 4'hA, 1'b0, 1'b0);
        run_read(1'b1, 4'h5, 4'hC, 1'b0, 1'b0);
        run_read(1'b1, 4'($urandom), 4'($urandom), 1'b1, 1'b1);
        run_read(1'b0, 4'($urandom), 4'($urandom), 1'b0, 1'b0);

        // Abort inside the first enable window.
        bus.rd_rs  = 1'b1;
        bus.rd_req = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_req = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        chk("abort_e_pre", 8'(bus.LCD_E), 8'h01);
        reset = 1'b1;
        #1;
        exp_data = 8'h00;
        chk_idle("abort_async");
        #2;
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.SF_D = 4'($urandom);
            @(negedge clk);
            chk_idle($sformatf("abort_quiet%0d", i));
        end

        run_read(1'b0, 4'h3, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            run_read(1'($urandom), 4'($urandom), 4'($urandom),
                     1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
